// File: rtl/spi_xfer_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_xfer_engine
// Description : SPI mode-0 master byte engine. A ready/valid byte stream is
//               shifted out MSB first while MISO is shifted in. Consecutive
//               bytes share one chip-select frame until a byte is tagged last.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_xfer_engine #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_last_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       busy_o,
  output logic       sck_o,
  output logic       mosi_o,
  input  logic       miso_i,
  output logic       csb_o
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  // The NEXT cycle already counts as the first cycle of CS hold time.
  localparam logic [CW-1:0] HOLD_START = (CLK_DIV > 1) ? CW'(1) : '0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    NEXT  = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      tx_sh_q, tx_sh_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            last_q, last_d;
  logic            sck_q, sck_d;
  logic            csb_q, csb_d;
  logic            mosi_q, mosi_d;
  logic            init_q;
  logic            tx_ready;
  logic            div_term;

  // State and datapath registers; reset forces the bus idle without a clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      last_q     <= 1'b0;
      sck_q      <= 1'b0;
      csb_q      <= 1'b1;
      mosi_q     <= 1'b0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      last_q     <= last_d;
      sck_q      <= sck_d;
      csb_q      <= csb_d;
      mosi_q     <= mosi_d;
      init_q     <= 1'b1;
    end
  end

  // Next-state logic: SCK generation, bit shifting and CS framing.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    last_d     = last_q;
    sck_d      = sck_q;
    csb_d      = csb_q;
    mosi_d     = mosi_q;
    tx_ready   = 1'b0;
    div_term   = (div_q == DIV_LAST);

    case (state_q)
      IDLE: begin
        // Ready is withheld until the first clock after reset release.
        tx_ready = init_q;
        if (tx_valid_i && init_q) begin
          tx_sh_d = tx_data_i;
          last_d  = tx_last_i;
          mosi_d  = tx_data_i[7];
          csb_d   = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (div_term) begin
          div_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            // Rising toggle: capture MISO.
            rx_sh_d = {rx_sh_q[6:0], miso_i};
          end else if (bit_q == 3'd7) begin
            // Eighth falling toggle: byte complete.
            bit_d      = '0;
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
            state_d    = NEXT;
          end else begin
            // Falling toggle: present the next TX bit.
            bit_d   = bit_q + 3'd1;
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
            mosi_d  = tx_sh_q[6];
          end
        end else begin
          div_d = div_q + CW'(1);
        end
      end

      NEXT: begin
        if (last_q) begin
          div_d   = HOLD_START;
          state_d = HOLD;
        end else begin
          // Frame stays open; wait as long as needed for the next byte.
          tx_ready = 1'b1;
          if (tx_valid_i) begin
            tx_sh_d = tx_data_i;
            last_d  = tx_last_i;
            mosi_d  = tx_data_i[7];
            div_d   = '0;
            bit_d   = '0;
            state_d = SHIFT;
          end
        end
      end

      HOLD: begin
        if (div_term) begin
          div_d   = '0;
          csb_d   = 1'b1;
          mosi_d  = 1'b0;
          state_d = GAP;
        end else begin
          div_d = div_q + CW'(1);
        end
      end

      GAP: begin
        if (div_term) begin
          div_d   = '0;
          state_d = IDLE;
        end else begin
          div_d = div_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        csb_d   = 1'b1;
        sck_d   = 1'b0;
        mosi_d  = 1'b0;
        div_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  assign tx_ready_o = tx_ready;
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;
  assign busy_o     = (state_q != IDLE);
  assign sck_o      = sck_q;
  assign mosi_o     = mosi_q;
  assign csb_o      = csb_q;

endmodule
`default_nettype wire
